adder_cpu_controller: RTL
=========================

// Module: adder_cpu_controller
// PURPOSE
//  Multi-cycle control FSM of the adding-machine CPU. Drives the PC (clr_pc/inc_pc/ld_pc),
//  IR, accumulator and memory strobes; consumes the IR opcode and the memory ready flag.
//  Sits directly upstream of the PC. One instruction = FETCH, DECODE, then one execute state.
//  Opcodes: 00 LDA (AC<=M[a]), 01 STA (M[a]<=AC), 10 ADD (AC<=AC+M[a]), 11 JMP (PC<=a).
// PARAMETERS
//  WAIT_LIMIT  16  max consecutive cycles a memory state may wait for mem_ready before error
//  CNT_W       5   width of wait counter; must hold WAIT_LIMIT
// PORTS
//  clk        in   1  single system clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  start      in   1  run request; sampled in IDLE and ERROR
//  stop       in   1  halt request; honoured only at instruction boundary
//  opcode     in   2  IR[7:6], valid from the cycle after ld_ir
//  mem_ready  in   1  memory completes current read/write this cycle
//  clr_pc     out  1  clear PC to 0
//  inc_pc     out  1  PC <= PC+1
//  ld_pc      out  1  PC <= IR address field
//  ld_ir      out  1  IR <= memory data
//  clr_ac     out  1  clear accumulator
//  ld_ac      out  1  AC <= ALU result
//  alu_sel    out  1  0 = pass memory data, 1 = AC + memory data (6-bit, carry dropped)
//  addr_sel   out  1  memory address: 0 = PC, 1 = IR address field
//  mem_read   out  1  memory read strobe
//  mem_write  out  1  memory write strobe
//  busy       out  1  high in every state except IDLE and ERROR
//  err        out  1  high in ERROR (memory timeout)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state IDLE, op_q=0, wait_cnt=0; every output 0.
//  - Outputs decoded from state (Moore) except the marked mem_ready-qualified (Mealy) ones.
//  - IDLE: start=1 -> INIT.  INIT (1 cycle): clr_pc=1, clr_ac=1 -> FETCH.
//  - FETCH: mem_read=1, addr_sel=0. Entry via RUN_CHK: if stop=1 -> IDLE instead.
//    mem_ready=1: ld_ir=1, inc_pc=1 (Mealy) -> DECODE; else stay.
//  - DECODE (1 cycle): op_q<=opcode; 00/10 -> EXEC_RD, 01 -> EXEC_WR, 11 -> EXEC_JMP.
//  - EXEC_RD: mem_read=1, addr_sel=1, alu_sel=(op_q==10). mem_ready=1: ld_ac=1 (Mealy) -> boundary.
//  - EXEC_WR: mem_write=1, addr_sel=1. mem_ready=1 -> boundary.
//  - EXEC_JMP (1 cycle): ld_pc=1 -> boundary.
//  - Instruction boundary: stop=1 -> IDLE (busy drops next cycle), else FETCH.
//    stop during FETCH wait or any EXEC state is ignored; must be held to the boundary.
//  - Wait timer: wait_cnt cleared on entry to FETCH/EXEC_RD/EXEC_WR; +1 each cycle
//    there with mem_ready=0. Reaching WAIT_LIMIT with mem_ready=0 -> ERROR, no strobes issued.
//    mem_ready=1 on the limit cycle wins (normal completion).
//  - ERROR: err=1, all strobes 0, sticky. start=1 -> INIT (full restart, err clears).
//  - start while busy is ignored. Never more than one of clr_pc/inc_pc/ld_pc high.
//  - mem_read and mem_write never high together. Reset mid-instruction aborts at once,
//    no strobe completes.
// STRUCTURE
//  - Shared package/header adder_cpu_pkg: state encodings, OP_LDA/OP_STA/OP_ADD/OP_JMP,
//    ALU_PASS/ALU_ADD, ADDR_PC/ADDR_IR constants.
//  - One sub-module mem_wait_timer (clear, enable, WAIT_LIMIT compare -> expired).
// TESTING
//  - Reset: rst_n=0 mid-EXEC_RD -> all outputs 0 immediately; state IDLE, busy=0.
//  - start pulse, mem_ready tied 1 -> INIT clr_pc+clr_ac; FETCH ld_ir+inc_pc same cycle;
//    LDA ld_ac with alu_sel=0; 3 cycles/instr after INIT.
//  - ADD, mem_ready delayed 3 cycles in EXEC_RD -> mem_read held 4 cycles;
//    ld_ac+alu_sel=1 only in the 4th.
//  - STA then JMP -> mem_write=1 & addr_sel=1 one cycle; EXEC_JMP ld_pc=1 then FETCH
//    with addr_sel=0.
//  - mem_ready held 0 in FETCH -> err=1 after 16 cycles, busy=0; start -> INIT, err=0.
//  - stop=1 asserted during EXEC_WR wait and held -> completes write, then IDLE;
//    no further FETCH.

Source files
------------

// File: rtl/adder_cpu_pkg.sv
// Shared definitions for the adding-machine CPU control path: FSM states, opcodes
// and the select encodings driven onto the datapath.
package adder_cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_RD,
        ST_EXEC_WR,
        ST_EXEC_JMP,
        ST_ERROR
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    localparam logic ALU_PASS = 1'b0;
    localparam logic ALU_ADD  = 1'b1;

    localparam logic ADDR_PC = 1'b0;
    localparam logic ADDR_IR = 1'b1;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_EXEC_RD) || (s == ST_EXEC_WR);
    endfunction

    function automatic state_t exec_state(input logic [1:0] op);
        state_t s;
        case (op)
            OP_LDA, OP_ADD: s = ST_EXEC_RD;
            OP_STA:         s = ST_EXEC_WR;
            default:        s = ST_EXEC_JMP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled cycles of one memory access; flags the stall cycle
// on which the count would reach WAIT_LIMIT.
module mem_wait_timer #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (enable) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    // The WAIT_LIMIT-th stalled cycle is the last one allowed.
    assign expired = enable && (wait_cnt == CNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/adder_cpu_controller.sv
// Multi-cycle control FSM of the adding-machine CPU: FETCH, DECODE, one execute
// state per instruction, with a memory-timeout ERROR state.
module adder_cpu_controller
    import adder_cpu_pkg::*;
#(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] opcode,
    input  logic       mem_ready,
    output logic       clr_pc,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ir,
    output logic       clr_ac,
    output logic       ld_ac,
    output logic       alu_sel,
    output logic       addr_sel,
    output logic       mem_read,
    output logic       mem_write,
    output logic       busy,
    output logic       err
);

    state_t     state_q;
    state_t     state_d;
    state_t     boundary;
    logic [1:0] op_q;
    logic       timer_clear;
    logic       timer_en;
    logic       expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // Every state change restarts the count, so each access gets a fresh budget.
    assign timer_clear = (state_d != state_q);
    assign timer_en    = is_mem_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .CNT_W      (CNT_W)
    ) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (expired)
    );

    assign boundary = stop ? ST_IDLE : ST_FETCH;

    always_comb begin
        state_d   = state_q;
        clr_pc    = 1'b0;
        inc_pc    = 1'b0;
        ld_pc     = 1'b0;
        ld_ir     = 1'b0;
        clr_ac    = 1'b0;
        ld_ac     = 1'b0;
        alu_sel   = ALU_PASS;
        addr_sel  = ADDR_PC;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b1;
        err       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                clr_pc  = 1'b1;
                clr_ac  = 1'b1;
                state_d = boundary;
            end
            ST_FETCH: begin
                mem_read = 1'b1;
                addr_sel = ADDR_PC;
                if (mem_ready) begin
                    ld_ir   = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                state_d = exec_state(opcode);
            end
            ST_EXEC_RD: begin
                mem_read = 1'b1;
                addr_sel = ADDR_IR;
                alu_sel  = (op_q == OP_ADD) ? ALU_ADD : ALU_PASS;
                if (mem_ready) begin
                    ld_ac   = 1'b1;
                    state_d = boundary;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_EXEC_WR: begin
                mem_write = 1'b1;
                addr_sel  = ADDR_IR;
                if (mem_ready) begin
                    state_d = boundary;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_EXEC_JMP: begin
                ld_pc   = 1'b1;
                state_d = boundary;
            end
            ST_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
                if (start) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
